// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector controller and its Moore core.
package seq_det_pkg;
  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = $clog2(DEF_W + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } ctrl_state_t;

  // Core states name the longest input suffix that is a prefix of "011" or "100".
  typedef enum logic [2:0] {
    C_IDLE = 3'd0,
    C_S0   = 3'd1,
    C_S01  = 3'd2,
    C_S011 = 3'd3,
    C_S1   = 3'd4,
    C_S10  = 3'd5,
    C_S100 = 3'd6
  } core_state_t;
endpackage

// File: rtl/seq_moore_core.sv
// 7-state Moore detector for the overlapping patterns "011" and "100".
// state  | meaning
// C_IDLE | nothing seen since reset
// C_S0   | suffix "0"
// C_S01  | suffix "01"
// C_S011 | "011" seen (output high)
// C_S1   | suffix "1"
// C_S10  | suffix "10"
// C_S100 | "100" seen (output high)
module seq_moore_core
  import seq_det_pkg::*;
(
  input  logic reset,
  input  logic clk,
  input  logic in_seq,
  output logic out_seq
);

  core_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= C_IDLE;
    end else begin
      case (state)
        C_IDLE:  state <= in_seq ? C_S1  : C_S0;
        C_S0:    state <= in_seq ? C_S01 : C_S0;
        C_S01:   state <= in_seq ? C_S011 : C_S10;
        C_S011:  state <= in_seq ? C_S1  : C_S10;
        C_S1:    state <= in_seq ? C_S1  : C_S10;
        C_S10:   state <= in_seq ? C_S01 : C_S100;
        C_S100:  state <= in_seq ? C_S01 : C_S0;
        default: state <= C_IDLE;
      endcase
    end
  end

  assign out_seq = (state == C_S011) || (state == C_S100);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit sequencer around seq_moore_core: accepts a word, scans it serially,
// and returns the number of detector hits over a result handshake.
// state | meaning
// IDLE  | ready for a word
// LOAD  | core cleared, hit count cleared
// SHIFT | one bit per cycle into the core, W cycles
// DRAIN | last bit's Moore output sampled
// DONE  | result held until taken
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int CNT_W     = $clog2(W + 1),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_hit,
  output logic             busy
);

  localparam int BC_W = $clog2(W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(W - 1);

  ctrl_state_t     state;
  logic [W-1:0]    shreg;
  logic [BC_W-1:0] bit_cnt;
  logic            applied_q;
  logic            core_in;
  logic            core_out;
  logic            core_rst;

  assign core_in  = (state == SHIFT) ? (MSB_FIRST ? shreg[W-1] : shreg[0]) : 1'b0;
  assign core_rst = reset | (state == LOAD) | clr;

  seq_moore_core u_core (
    .reset   (core_rst),
    .clk     (clk),
    .in_seq  (core_in),
    .out_seq (core_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_count <= '0;
      res_hit   <= 1'b0;
      busy      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      applied_q <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_count <= '0;
      res_hit   <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      applied_q <= 1'b0;
    end else begin
      // Moore output lags its bit by one cycle, so count one cycle behind SHIFT
      applied_q <= (state == SHIFT);
      if (applied_q && core_out) begin
        res_count <= res_count + CNT_W'(1);
        res_hit   <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            state    <= LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          res_count <= '0;
          res_hit   <= 1'b0;
          bit_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          shreg   <= MSB_FIRST ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};
          bit_cnt <= bit_cnt + BC_W'(1);
          if (bit_cnt == LAST_BIT) state <= DRAIN;
        end
        DRAIN: begin
          state     <= DONE;
          res_valid <= 1'b1;
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl (W=8, MSB first) with a window-based reference model.
module tb_seq_detect_ctrl;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_hit;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  seq_detect_ctrl #(.W(W), .CNT_W(CNT_W), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_hit   (res_hit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count 3-bit windows equal to 011 or 100 in shift order (MSB first).
  function automatic int model_count(input logic [W-1:0] w);
    logic [W-1:0] b;
    int c;
    c = 0;
    for (int k = 0; k < W; k++) b[k] = w[W-1-k];
    for (int k = 2; k < W; k++) begin
      if ({b[k-2], b[k-1], b[k]} == 3'b100 || {b[k-2], b[k-1], b[k]} == 3'b011) c++;
    end
    return c;
  endfunction

  task automatic send_word(input logic [W-1:0] w, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(model_count(w));
      #1;
      in_data = W'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, output int cnt, output bit hit, output bit ok);
    ok  = 1'b0;
    cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      cnt = int'(res_count);
      hit = res_hit;
      repeat (hold) @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit ok;
    bit seen;
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, busy, res_valid, res_hit, res_count} !== {3'b100, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b busy=%b vld=%b hit=%b cnt=%0d, want rdy=1 busy=0 vld=0 hit=0 cnt=0",
               in_ready, busy, res_valid, res_hit, res_count);
    end
    reset = 1'b0;
    send_word(8'hA5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reset_accept: got no accept, want accept"); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, busy, res_valid, res_count} !== {3'b100, 4'd0}) begin
      n_err++;
      $display("FAIL reset_midshift: got rdy=%b busy=%b vld=%b cnt=%0d, want rdy=1 busy=0 vld=0 cnt=0",
               in_ready, busy, res_valid, res_count);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL reset_job_lost: got res_valid=%b, want 0", seen); end
  endtask

  task automatic test_single_words();
    logic [W-1:0] words [3];
    int           want  [3];
    bit ok;
    int cnt;
    bit hit;
    int edges;
    int e;
    words = '{8'b0010_0000, 8'h00, 8'b1100_0000};
    want  = '{1, 0, 1};
    for (int j = 0; j < 3; j++) begin
      send_word(words[j], ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL single_accept[%0d]: got no accept, want accept", j); end
      // accept edge counted as edge 1
      edges = 1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (res_valid) break;
        @(posedge clk);
        edges++;
      end
      n_cmp++;
      if (edges != W + 3) begin
        n_err++;
        $display("FAIL single_latency[%0d]: got %0d edges, want %0d", j, edges, W + 3);
      end
      wait_result(0, cnt, hit, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || cnt !== want[j] || cnt !== e) begin
        n_err++;
        $display("FAIL single_count[%0d]: got %0d (valid=%b), want %0d", j, cnt, ok, want[j]);
      end
      n_cmp++;
      if (hit !== (want[j] != 0)) begin
        n_err++;
        $display("FAIL single_hit[%0d]: got %b, want %b", j, hit, want[j] != 0);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int e;
    int e2;
    int bad;
    int cnt;
    bit hit;
    send_word(8'b0010_0000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_accept: got no accept, want accept"); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    e = exp_q.pop_front();
    in_valid = 1'b1;
    in_data  = 8'b1100_0000;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || int'(res_count) !== e || in_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: got %0d bad cycles (vld=%b cnt=%0d rdy=%b), want 0 (cnt=%0d)",
               bad, res_valid, res_count, in_ready, e);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, busy, res_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL bp_idle: got rdy=%b busy=%b vld=%b, want 1 0 0", in_ready, busy, res_valid);
    end
    @(posedge clk);
    exp_q.push_back(model_count(8'b1100_0000));
    #1 in_valid = 1'b0;
    in_data = 8'hFF;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL bp_late_accept: got busy=%b, want 1", busy); end
    wait_result(1, cnt, hit, ok);
    e2 = exp_q.pop_front();
    n_cmp++;
    if (!ok || cnt !== e2 || cnt !== 1) begin
      n_err++;
      $display("FAIL bp_second_count: got %0d (valid=%b), want %0d", cnt, ok, e2);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [4];
    bit ok;
    int cnt;
    bit hit;
    int e;
    words = '{8'b0010_0000, 8'h00, 8'b0000_0001, 8'b1000_0000};
    for (int j = 0; j < 4; j++) begin
      send_word(words[j], ok);
      wait_result(0, cnt, hit, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || cnt !== e || hit !== (e != 0)) begin
        n_err++;
        $display("FAIL b2b_count[%0d]: got %0d hit=%b (valid=%b), want %0d", j, cnt, hit, ok, e);
      end
    end
  endtask

  task automatic test_clr();
    bit ok;
    bit seen;
    int cnt;
    bit hit;
    int e;
    send_word(8'b0010_0000, ok);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    n_cmp++;
    if ({in_ready, busy, res_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL clr_shift: got rdy=%b busy=%b vld=%b, want 1 0 0", in_ready, busy, res_valid);
    end
    exp_q.delete();
    seen = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL clr_no_result: got res_valid=%b, want 0", seen); end

    send_word(8'b1100_0000, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    clr = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    res_ready = 1'b0;
    n_cmp++;
    if ({in_ready, busy, res_valid, res_count} !== {3'b100, 4'd0}) begin
      n_err++;
      $display("FAIL clr_done: got rdy=%b busy=%b vld=%b cnt=%0d, want 1 0 0 0",
               in_ready, busy, res_valid, res_count);
    end
    exp_q.delete();

    send_word(8'b0010_0000, ok);
    wait_result(0, cnt, hit, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || cnt !== e || cnt !== 1) begin
      n_err++;
      $display("FAIL clr_next_job: got %0d (valid=%b), want %0d", cnt, ok, e);
    end
  endtask

  task automatic test_random();
    bit ok;
    int cnt;
    bit hit;
    int e;
    for (int j = 0; j < 1000; j++) begin
      send_word(W'($urandom), ok);
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand_accept[%0d]: got no accept, want accept", j);
        break;
      end
      wait_result($urandom_range(0, 2), cnt, hit, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || cnt !== e || hit !== (e != 0)) begin
        n_err++;
        $display("FAIL rand_count[%0d]: got %0d hit=%b (valid=%b), want %0d", j, cnt, hit, ok, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_words();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
